// File: rtl/vx_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// vx_ram_fifo_ctrl
//
// Purpose:
//   Streaming first-word-fall-through FIFO controller around an external
//   dual-port RAM (VX_dp_ram_asic, WRENW=1, SIZE=DEPTH). The RAM has a
//   registered read port that holds its output while not reading. That
//   rdata register is used as the FIFO head: deq_data is wired straight to
//   ram_rdata. A word's RAM slot is released as soon as its read issues, so
//   the total capacity is DEPTH+1 (DEPTH in RAM plus one in rdata).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
//   are both high. enq_ready does not depend on enq_valid, deq_ready or
//   enq_data. deq_valid does not depend on deq_ready. A producer may drop
//   enq_valid before acceptance. A consumer may raise deq_ready while
//   deq_valid is low, and nothing happens.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   enq_valid/ready     producer handshake, payload enq_data
//   deq_valid/ready     consumer handshake, payload deq_data (= ram_rdata)
//   count               total occupancy, 0..DEPTH+1
//   ram_write/waddr/wdata   RAM write port (RAM wren tied high)
//   ram_read/raddr          RAM read port (rdata updates on next edge)
//   ram_rdata               RAM registered read data (cleared by reset)
//
// Latency: an enqueue at cycle T issues its RAM read at T+1 when the FIFO
//   is empty, and the word shows up as the head at T+2.
// ---------------------------------------------------------------------------
module vx_ram_fifo_ctrl #(
  parameter int DATAW = 32,
  parameter int DEPTH = 16,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_valid,
  input  logic [DATAW-1:0]   enq_data,
  output logic               enq_ready,
  output logic               deq_valid,
  output logic [DATAW-1:0]   deq_data,
  input  logic               deq_ready,
  output logic [ADDRW+1:0]   count,
  output logic               ram_write,
  output logic [ADDRW-1:0]   ram_waddr,
  output logic [DATAW-1:0]   ram_wdata,
  output logic               ram_read,
  output logic [ADDRW-1:0]   ram_raddr,
  input  logic [DATAW-1:0]   ram_rdata
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("vx_ram_fifo_ctrl: DEPTH must be a power of 2 and >= 2");
  end

  localparam logic [ADDRW:0] DEPTH_CNT = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0] PTR_ONE   = (ADDRW+1)'(1);

  // Pointers carry one extra bit so full (DEPTH) and empty (0) differ.
  logic [ADDRW:0] wr_ptr;
  logic [ADDRW:0] rd_ptr;
  logic [ADDRW:0] ram_cnt;
  logic           out_valid;
  logic           enq_fire;

  assign ram_cnt = wr_ptr - rd_ptr;

  // Only registered state feeds enq_ready, so a dequeue in the same cycle
  // as a full FIFO does not open a slot until the next cycle.
  assign enq_ready = !reset && (ram_cnt < DEPTH_CNT);
  assign enq_fire  = enq_valid && enq_ready;

  assign ram_write = enq_fire;
  assign ram_waddr = wr_ptr[ADDRW-1:0];
  assign ram_wdata = enq_data;

  // Refill rdata whenever it is empty or its word is being consumed. Since
  // ram_cnt is registered, a word is never read in the cycle it is written.
  assign ram_read  = (ram_cnt != '0) && (!out_valid || deq_ready);
  assign ram_raddr = rd_ptr[ADDRW-1:0];

  assign deq_valid = out_valid;
  assign deq_data  = ram_rdata;
  assign count     = (ADDRW+2)'(ram_cnt) + (ADDRW+2)'(out_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (ram_read) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        out_valid <= 1'b1;
      end else if (out_valid && deq_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Both RAM ports must never touch the same slot in the same cycle.
  no_collision: assert property (@(posedge clk) disable iff (reset)
    !(ram_write && ram_read && (ram_waddr == ram_raddr)));

  occupancy_bound: assert property (@(posedge clk) disable iff (reset)
    (ram_cnt <= DEPTH_CNT));

endmodule

// File: tb/tb_vx_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vx_ram_fifo_ctrl
//
// Bench for vx_ram_fifo_ctrl with DEPTH=4, DATAW=32. It holds a model of
// the external RAM (registered read, hold on idle, rdata cleared by reset).
// The reference model is a queue of accepted words, each tagged with its
// acceptance cycle. Its rules are:
//   count     = number of words accepted but not yet dequeued
//   enq_ready = !reset && count < DEPTH+1
//   deq_valid = queue not empty && head accepted at least 2 cycles ago
//   deq_data  = head of the queue whenever deq_valid is high
// ---------------------------------------------------------------------------
module tb_vx_ram_fifo_ctrl;

  localparam int DATAW = 32;
  localparam int DEPTH = 4;
  localparam int ADDRW = $clog2(DEPTH);

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             enq_valid;
  logic [DATAW-1:0] enq_data;
  logic             enq_ready;
  logic             deq_valid;
  logic [DATAW-1:0] deq_data;
  logic             deq_ready;
  logic [ADDRW+1:0] count;
  logic             ram_write;
  logic [ADDRW-1:0] ram_waddr;
  logic [DATAW-1:0] ram_wdata;
  logic             ram_read;
  logic [ADDRW-1:0] ram_raddr;
  logic [DATAW-1:0] ram_rdata;

  vx_ram_fifo_ctrl #(.DATAW(DATAW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_ready (deq_ready),
    .count     (count),
    .ram_write (ram_write),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_read  (ram_read),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata)
  );

  // external RAM model
  logic [DATAW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write) mem[ram_waddr] <= ram_wdata;
    if (reset) ram_rdata <= '0;
    else if (ram_read) ram_rdata <= mem[ram_raddr];
  end

  // scoreboard / model
  logic [DATAW-1:0] exp_q[$];
  int               acc_q[$];
  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;

  logic             last_enq_fire;
  logic             last_deq_fire;
  logic [DATAW-1:0] last_deq_data;
  logic             last_ram_read;

  // One clock cycle: drive inputs just after a negedge, check outputs
  // against the model, update the model, and advance to the next negedge.
  task automatic cycle(input logic rst, input logic ev,
                       input logic [DATAW-1:0] ed, input logic dr);
    logic             exp_rdy;
    logic             exp_dv;
    logic [ADDRW+1:0] exp_cnt;
    logic [DATAW-1:0] exp_head;
    reset = rst; enq_valid = ev; enq_data = ed; deq_ready = dr;
    #1;
    exp_cnt = (ADDRW+2)'(exp_q.size());
    exp_rdy = !rst && (exp_q.size() < DEPTH + 1);
    exp_dv  = 1'b0;
    exp_head = '0;
    if (exp_q.size() != 0) begin
      exp_dv   = (cyc >= acc_q[0] + 2);
      exp_head = exp_q[0];
    end
    checks++;
    if (count !== exp_cnt) begin
      failures++;
      $display("FAIL count cyc=%0d actual=%0d expected=%0d", cyc, count, exp_cnt);
    end
    checks++;
    if (enq_ready !== exp_rdy) begin
      failures++;
      $display("FAIL enq_ready cyc=%0d actual=%b expected=%b", cyc, enq_ready, exp_rdy);
    end
    checks++;
    if (deq_valid !== exp_dv) begin
      failures++;
      $display("FAIL deq_valid cyc=%0d actual=%b expected=%b", cyc, deq_valid, exp_dv);
    end
    if (exp_dv) begin
      checks++;
      if (deq_data !== exp_head) begin
        failures++;
        $display("FAIL deq_data cyc=%0d actual=%h expected=%h", cyc, deq_data, exp_head);
      end
    end
    checks++;
    if (ram_write && ram_read && (ram_waddr == ram_raddr)) begin
      failures++;
      $display("FAIL ram_collision cyc=%0d addr=%0d actual=1 expected=0", cyc, ram_waddr);
    end
    last_enq_fire = ev && enq_ready;
    last_deq_fire = deq_valid && dr;
    last_deq_data = deq_data;
    last_ram_read = ram_read;
    if (last_deq_fire) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL deq_underflow cyc=%0d actual=%h expected=none", cyc, deq_data);
      end else begin
        exp_head = exp_q.pop_front();
        void'(acc_q.pop_front());
        if (deq_data !== exp_head) begin
          failures++;
          $display("FAIL deq_order cyc=%0d actual=%h expected=%h", cyc, deq_data, exp_head);
        end
      end
    end
    if (last_enq_fire) begin
      exp_q.push_back(ed);
      acc_q.push_back(cyc);
    end
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 words left", exp_q.size());
    end
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 32'h55, 1'b1);
    checks++;
    if (deq_data !== '0) begin
      failures++;
      $display("FAIL reset_deq_data actual=%h expected=0", deq_data);
    end
    cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  // Fill with deq stalled: 5 words fit, the 6th waits.
  task automatic test_fill();
    logic [DATAW-1:0] d = 32'h10;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, d != 32'h16, d, 1'b0);
      if (last_enq_fire) d++;
    end
    checks++;
    if (d !== 32'h15) begin
      failures++;
      $display("FAIL fill_accepted actual=%h expected=15 (next data)", d);
    end
    checks++;
    if (count !== 5 || enq_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full actual=count %0d rdy %b expected=count 5 rdy 0", count, enq_ready);
    end
    checks++;
    if (deq_valid !== 1'b1 || deq_data !== 32'h10) begin
      failures++;
      $display("FAIL fill_head actual=%b/%h expected=1/10", deq_valid, deq_data);
    end
  endtask

  task automatic test_drain_sequence();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (last_deq_fire !== 1'b1 || last_deq_data !== 32'(32'h10 + i)) begin
        failures++;
        $display("FAIL drain_seq i=%0d actual=%b/%h expected=1/%h", i, last_deq_fire,
                 last_deq_data, 32'h10 + i);
      end
    end
    checks++;
    if (deq_valid !== 1'b0 || count !== 0) begin
      failures++;
      $display("FAIL drain_empty actual=%b/%0d expected=0/0", deq_valid, count);
    end
  endtask

  task automatic test_latency();
    cycle(1'b0, 1'b1, 32'hAB, 1'b0);
    checks++;
    if (last_ram_read !== 1'b0) begin
      failures++;
      $display("FAIL lat_read_T actual=%b expected=0", last_ram_read);
    end
    cycle(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (last_ram_read !== 1'b1) begin
      failures++;
      $display("FAIL lat_read_T1 actual=%b expected=1", last_ram_read);
    end
    checks++;
    if (deq_valid !== 1'b1 || deq_data !== 32'hAB) begin
      failures++;
      $display("FAIL lat_head_T2 actual=%b/%h expected=1/ab", deq_valid, deq_data);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [DATAW-1:0] d = '0;
    int fires = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, d, 1'b1);
      if (last_enq_fire) d++;
      if (i >= 2 && last_deq_fire) fires++;
    end
    checks++;
    if (d !== 32'd40 || fires != 38) begin
      failures++;
      $display("FAIL b2b_rate actual=in %0d out %0d expected=in 40 out 38", d, fires);
    end
    drain();
  endtask

  task automatic test_full_with_deq();
    logic [DATAW-1:0] d = 32'h60;
    int n = 0;
    while (count != 5 && n < 10) begin
      cycle(1'b0, 1'b1, d, 1'b0);
      if (last_enq_fire) d++;
      n++;
    end
    checks++;
    if (count !== 5) begin
      failures++;
      $display("FAIL full_reach actual=%0d expected=5", count);
    end
    cycle(1'b0, 1'b1, 32'h77, 1'b1);
    checks++;
    if (last_enq_fire !== 1'b0 || last_deq_fire !== 1'b1) begin
      failures++;
      $display("FAIL full_deq_cycle actual=enq %b deq %b expected=enq 0 deq 1",
               last_enq_fire, last_deq_fire);
    end
    checks++;
    if (count !== 4 || enq_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_after actual=count %0d rdy %b expected=count 4 rdy 1", count, enq_ready);
    end
    cycle(1'b0, 1'b1, 32'h77, 1'b0);
    checks++;
    if (count !== 5) begin
      failures++;
      $display("FAIL full_refill actual=%0d expected=5", count);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'(32'hC0 + i), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (count !== 3 || deq_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup actual=%0d/%b expected=3/1", count, deq_valid);
    end
    cycle(1'b1, 1'b1, 32'hEE, 1'b1);
    checks++;
    if (last_ram_read !== 1'b1) begin
      failures++;
      $display("FAIL mid_read_inflight actual=%b expected=1", last_ram_read);
    end
    checks++;
    if (deq_valid !== 1'b0 || count !== 0 || deq_data !== '0 || enq_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_post_reset actual=%b/%0d/%h/%b expected=0/0/0/0 (reset still high)",
               deq_valid, count, deq_data, enq_ready);
    end
    cycle(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (deq_data !== '0) begin
      failures++;
      $display("FAIL mid_deq_data actual=%h expected=0", deq_data);
    end
  endtask

  task automatic test_random();
    int words_in = 0;
    int words_out = 0;
    int n = 0;
    logic [DATAW-1:0] d = $urandom;
    logic ev;
    logic dr;
    while (words_out < 10000 && n < 40000) begin
      ev = (words_in < 10000) && ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      cycle(1'b0, ev, d, dr);
      if (last_enq_fire) begin
        words_in++;
        d = $urandom;
      end
      if (last_deq_fire) words_out++;
      n++;
    end
    checks++;
    if (words_out != 10000) begin
      failures++;
      $display("FAIL random_timeout actual=%0d expected=10000 words", words_out);
    end
  endtask

  initial begin
    reset = 1'b1; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_fill();
    test_drain_sequence();
    test_latency();
    test_back_to_back();
    test_full_with_deq();
    test_reset_midflight();
    test_random();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
